// File: rtl/fsm_in.sv
// Ingress packet parser: matches DA against port addresses and streams matched packets into the output FIFOs.
// Optional broadcast (DA all-ones writes every FIFO) is enabled by defining FSM_IN_BCAST_EN.
module fsm_in #(
  parameter int W_WIDTH   = 8,
  parameter int NUM_PORTS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [W_WIDTH-1:0]             data_in,
  input  logic                           sw_enable_in,
  output logic                           read_out,
  input  logic [NUM_PORTS*W_WIDTH-1:0]   port_addr,
  input  logic [NUM_PORTS-1:0]           fifo_full,
  output logic [NUM_PORTS-1:0]           wr_en,
  output logic [W_WIDTH-1:0]             fifo_data,
  output logic                           drop
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SA      = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DPH_SA  = 2'd0,
    DPH_LEN = 2'd1,
    DPH_PAY = 2'd2
  } dphase_t;

  state_t                 state_q;
  dphase_t                dph_q;
  logic [NUM_PORTS-1:0]   mask_q;
  logic [W_WIDTH-1:0]     cnt_q;
  logic                   drop_q;

  logic [NUM_PORTS-1:0]   match;
  logic                   acc;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      match[i] = (data_in == port_addr[i*W_WIDTH +: W_WIDTH]);
    end
`ifdef FSM_IN_BCAST_EN
    if (&data_in) begin
      match = '1;
    end
`endif
  end

  // Any full target holds off the whole byte, so multicast copies never diverge.
  always_comb begin
    read_out = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE:  read_out = ~|(match & fifo_full);
        S_DROP:  read_out = 1'b1;
        default: read_out = ~|(mask_q & fifo_full);
      endcase
    end
  end

  assign acc       = sw_enable_in & read_out;
  assign fifo_data = data_in;
  assign drop      = drop_q;

  always_comb begin
    wr_en = '0;
    if (acc) begin
      case (state_q)
        S_IDLE:  wr_en = match;
        S_DROP:  wr_en = '0;
        default: wr_en = mask_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dph_q   <= DPH_SA;
      mask_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (acc) begin
        case (state_q)
          S_IDLE: begin
            if (|match) begin
              mask_q  <= match;
              state_q <= S_SA;
            end else begin
              dph_q   <= DPH_SA;
              drop_q  <= 1'b1;
              state_q <= S_DROP;
            end
          end
          S_SA: state_q <= S_LEN;
          S_LEN: begin
            cnt_q   <= data_in;
            state_q <= (data_in != '0) ? S_PAYLOAD : S_IDLE;
          end
          S_PAYLOAD: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == W_WIDTH'(1)) state_q <= S_IDLE;
          end
          S_DROP: begin
            // Discarded packets walk the same SA/LEN/payload sequence without writing.
            case (dph_q)
              DPH_SA: dph_q <= DPH_LEN;
              DPH_LEN: begin
                cnt_q <= data_in;
                if (data_in == '0) state_q <= S_IDLE;
                else               dph_q   <= DPH_PAY;
              end
              default: begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == W_WIDTH'(1)) state_q <= S_IDLE;
              end
            endcase
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsm_in.sv
// Scoreboard bench for fsm_in: driver queues expected FIFO writes, a negedge monitor pops and compares them.
module tb_fsm_in;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        sw_enable_in;
  logic        read_out;
  logic [31:0] port_addr;
  logic [3:0]  fifo_full;
  logic [3:0]  wr_en;
  logic [7:0]  fifo_data;
  logic        drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [11:0] sb[$];

  fsm_in #(.W_WIDTH(8), .NUM_PORTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sw_enable_in(sw_enable_in),
    .read_out(read_out), .port_addr(port_addr), .fifo_full(fifo_full),
    .wr_en(wr_en), .fifo_data(fifo_data), .drop(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed write must be the next expected one
  always @(negedge clk) begin
    if (rst_n && wr_en != 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected actual wr_en=%b data=%h required none", wr_en, fifo_data);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        if (e != {wr_en, fifo_data}) begin
          errors++;
          $display("FAIL write actual wr_en=%b data=%h required wr_en=%b data=%h",
                   wr_en, fifo_data, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Present one byte, wait (bounded) for ready, let it be accepted; sw_enable_in stays high.
  task automatic send(input logic [7:0] b, input logic [3:0] exp);
    int n;
    n = 0;
    data_in = b;
    sw_enable_in = 1'b1;
    if (exp != 4'b0) sb.push_back({exp, b});
    @(negedge clk);
    while (!read_out && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!read_out) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual read_out=0 required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sw_enable_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    sw_enable_in = 1'b1;
    data_in = 8'h22;
    port_addr = {8'h44, 8'h33, 8'h22, 8'h11};
    fifo_full = 4'b0;

    // Reset state
    @(negedge clk);
    chk("rst_read_out", read_out, 0);
    chk("rst_wr_en", wr_en, 0);
    @(posedge clk); #1;
    chk("rst_drop", drop, 0);
    rst_n = 1'b1;
    sw_enable_in = 1'b0;
    idle(1);

    // Basic unicast to port 1, enable held
    t0 = cyc;
    send(8'h22, 4'b0010);
    chk("match_no_drop", drop, 0);
    send(8'h01, 4'b0010); send(8'h03, 4'b0010);
    send(8'hA0, 4'b0010); send(8'hA1, 4'b0010); send(8'hA2, 4'b0010);
    chk("pkt1_cycles", cyc - t0, 6);

    // Unmatched DA dropped, then a port-0 packet
    send(8'h99, 4'b0);
    chk("drop_pulse", drop, 1);
    send(8'h01, 4'b0);
    chk("drop_one_cycle", drop, 0);
    send(8'h02, 4'b0); send(8'hB0, 4'b0); send(8'hB1, 4'b0);
    send(8'h11, 4'b0001); send(8'h02, 4'b0001); send(8'h01, 4'b0001); send(8'hC0, 4'b0001);
    idle(2);

    // Backpressure on port 1 plus mid-packet address change
    send(8'h22, 4'b0010);
    port_addr = {8'h44, 8'h33, 8'h55, 8'h22};
    send(8'h03, 4'b0010); send(8'h03, 4'b0010); send(8'hD0, 4'b0010);
    fifo_full = 4'b0010;
    data_in = 8'hD1;
    for (int i = 0; i < 4; i++) begin
      fifo_full[2] = ~fifo_full[2];
      @(negedge clk);
      chk("stall_read_out", read_out, 0);
      chk("stall_wr_en", wr_en, 0);
      @(posedge clk); #1;
    end
    fifo_full = 4'b0100;
    send(8'hD1, 4'b0010);
    fifo_full = 4'b0;
    send(8'hD2, 4'b0010);
    port_addr = {8'h44, 8'h33, 8'h22, 8'h11};

    // LEN=0 packet followed immediately by LEN=1 packet
    t0 = cyc;
    send(8'h33, 4'b0100); send(8'h04, 4'b0100); send(8'h00, 4'b0100);
    send(8'h44, 4'b1000); send(8'h05, 4'b1000); send(8'h01, 4'b1000); send(8'hE0, 4'b1000);
    chk("b2b_cycles", cyc - t0, 7);
    idle(1);

    // Reset mid-payload abandons the packet
    send(8'h11, 4'b0001); send(8'h06, 4'b0001); send(8'h0A, 4'b0001);
    send(8'hF0, 4'b0001); send(8'hF1, 4'b0001);
    rst_n = 1'b0;
    data_in = 8'h11;
    @(negedge clk);
    chk("midrst_read_out", read_out, 0);
    chk("midrst_wr_en", wr_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h44, 4'b1000); send(8'h07, 4'b1000); send(8'h00, 4'b1000);
    idle(1);

    // All-ones DA
`ifdef FSM_IN_BCAST_EN
    send(8'hFF, 4'b1111);
    chk("bcast_no_drop", drop, 0);
    send(8'h08, 4'b1111); send(8'h01, 4'b1111); send(8'h99, 4'b1111);
`else
    send(8'hFF, 4'b0);
    chk("ff_drop", drop, 1);
    send(8'h08, 4'b0); send(8'h01, 4'b0); send(8'h99, 4'b0);
`endif
    idle(3);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
